// File: rtl/binary_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_seq
//
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble)
// method. One operand bit is consumed per clock, so a conversion takes
// BIN_WIDTH shift cycles plus one cycle to publish the result.
//
// Parameters
//   BIN_WIDTH : width of the binary operand (4..32)
//   DIGITS    : number of BCD digits produced (1..10)
//
// Ports
//   clk      : clock, rising edge active
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, only looked at while idle
//   binIn    : unsigned operand, captured on the accepted start cycle
//   busy     : high while a conversion is in flight (SHIFT and DONE)
//   done     : one-cycle pulse when bcdOut/overflow carry a new result
//   bcdOut   : result, digit k at [4k+3:4k], digit 0 = ones
//   overflow : last result did not fit in DIGITS digits (bcdOut is mod 10^DIGITS)
//
// Optional feature
//   BCD_LEADING_BLANK_EN : when defined, leading zero digits above the most
//   significant nonzero digit are published as 4'hF (blank). Digit 0 is never
//   blanked and overflowed results are published unblanked.
// -----------------------------------------------------------------------------
module binary_to_bcd_seq #(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binIn,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcdOut,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [BIN_WIDTH-1:0]  operand;
  logic [SW-1:0]         scratch;
  logic [CW-1:0]         count;
  logic                  lost;      // a 1 has left the top digit this conversion
  logic [SW-1:0]         adjusted;  // scratch after the add-3 correction

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = s[4*k +: 4];
      end
    end
    return r;
  endfunction

`ifdef BCD_LEADING_BLANK_EN
  // Replace zero digits above the most significant nonzero digit with 4'hF.
  // Walks from the top digit down; digit 0 is left untouched.
  function automatic logic [SW-1:0] blank_leading(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          seen;
    r    = s;
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (s[4*k +: 4] != 4'd0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      if (seen) begin
        r[4*k +: 4] = s[4*k +: 4];
      end else begin
        r[4*k +: 4] = 4'hF;
      end
    end
    return r;
  endfunction
`endif

  // Correction stage feeding the shift; purely a function of the scratch register.
  assign adjusted = add3(scratch);

  // Conversion FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      operand  <= '0;
      scratch  <= '0;
      count    <= '0;
      lost     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcdOut   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= binIn;
            scratch <= '0;
            count   <= '0;
            lost    <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // {scratch, operand} shifted left by one after correction; the bit
          // leaving the top digit is remembered as overflow.
          scratch <= {adjusted[SW-2:0], operand[BIN_WIDTH-1]};
          operand <= {operand[BIN_WIDTH-2:0], 1'b0};
          lost    <= lost | adjusted[SW-1];
          count   <= count + CW'(1);
          if (count == CW'(BIN_WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
`ifdef BCD_LEADING_BLANK_EN
          bcdOut <= lost ? scratch : blank_leading(scratch);
`else
          bcdOut <= scratch;
`endif
          overflow <= lost;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
module tb_binary_to_bcd_seq;

  localparam int BW0 = 7;
  localparam int D0  = 3;
  localparam int BW1 = 7;
  localparam int D1  = 2;
  localparam int BW2 = 16;
  localparam int D2  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start0, start1, start2;
  logic [BW0-1:0]    bin0;
  logic [BW1-1:0]    bin1;
  logic [BW2-1:0]    bin2;
  logic              busy0, busy1, busy2;
  logic              done0, done1, done2;
  logic [4*D0-1:0]   bcd0;
  logic [4*D1-1:0]   bcd1;
  logic [4*D2-1:0]   bcd2;
  logic              ovf0, ovf1, ovf2;

  binary_to_bcd_seq #(.BIN_WIDTH(BW0), .DIGITS(D0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .binIn(bin0),
    .busy(busy0), .done(done0), .bcdOut(bcd0), .overflow(ovf0));

  binary_to_bcd_seq #(.BIN_WIDTH(BW1), .DIGITS(D1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .binIn(bin1),
    .busy(busy1), .done(done1), .bcdOut(bcd1), .overflow(ovf1));

  binary_to_bcd_seq #(.BIN_WIDTH(BW2), .DIGITS(D2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .binIn(bin2),
    .busy(busy2), .done(done2), .bcdOut(bcd2), .overflow(ovf2));

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    int          unit;
    longint      cyc;   // cycle index at which done must be seen
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  longint      cyc = 0;
  longint      last_acc [3];
  logic [39:0] hold_bcd [3];
  logic        hold_ovf [3];

  // Edge counter: value after edge N is N.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bw_of(input int u);
    return (u == 2) ? BW2 : BW0;
  endfunction

  // Reference: plain decimal arithmetic on the operand value.
  function automatic exp_t model(input longint unsigned v, input int digits);
    exp_t e;
    longint unsigned lim, r;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.ovf  = (v >= lim);
    r      = v % lim;
    e.bcd  = '0;
    e.unit = 0;
    e.cyc  = 0;
    for (int k = 0; k < digits; k++) begin
      e.bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef BCD_LEADING_BLANK_EN
    if (!e.ovf) begin
      longint unsigned t;
      int nd;
      t  = v;
      nd = 1;
      while (t >= 10) begin
        t  = t / 10;
        nd = nd + 1;
      end
      for (int k = nd; k < digits; k++) e.bcd[4*k +: 4] = 4'hF;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic mon(input int u, input logic b, input logic d,
                     input logic [39:0] bcd, input logic ovf);
    exp_t  e;
    logic  exp_busy;
    string s;
    s = $sformatf("u%0d", u);
    exp_busy = (cyc >= last_acc[u]) && (cyc <= last_acc[u] + longint'(bw_of(u)));
    chk({s, "_busy"}, 40'(b), 40'(exp_busy));
    if (d) begin
      if (q.size() == 0 || q[0].unit != u) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_done at cycle %0d: got done=1 expected no done", s, cyc);
      end else begin
        e = q.pop_front();
        chk({s, "_bcd"}, bcd, e.bcd);
        chk({s, "_ovf"}, 40'(ovf), 40'(e.ovf));
        chk({s, "_latency"}, 40'(cyc), 40'(e.cyc));
        hold_bcd[u] = e.bcd;
        hold_ovf[u] = e.ovf;
      end
    end else begin
      chk({s, "_hold_bcd"}, bcd, hold_bcd[u]);
      chk({s, "_hold_ovf"}, 40'(ovf), 40'(hold_ovf[u]));
    end
  endtask

  // Monitor: compares every DUT output against the scoreboard each cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outs0", {busy0, done0, ovf0, 28'(bcd0)}, 40'd0);
      chk("rst_outs1", {busy1, done1, ovf1, 28'(bcd1)}, 40'd0);
      chk("rst_outs2", {busy2, done2, ovf2, 20'(bcd2)}, 40'd0);
      for (int u = 0; u < 3; u++) begin
        hold_bcd[u] = '0;
        hold_ovf[u] = 1'b0;
      end
    end else begin
      mon(0, busy0, done0, 40'(bcd0), ovf0);
      mon(1, busy1, done1, 40'(bcd1), ovf1);
      mon(2, busy2, done2, 40'(bcd2), ovf2);
    end
  end

  task automatic set_in(input int u, input logic s, input logic [31:0] v);
    case (u)
      0:       begin start0 = s; bin0 = v[BW0-1:0]; end
      1:       begin start1 = s; bin1 = v[BW1-1:0]; end
      default: begin start2 = s; bin2 = v[BW2-1:0]; end
    endcase
  endtask

  // Issue one conversion at a negedge; scribble on start/binIn while busy.
  task automatic issue(input int u, input logic [31:0] v, input int gap);
    exp_t   e;
    longint acc;
    int     bw;
    int     dg;
    logic [31:0] m;
    bw  = bw_of(u);
    dg  = (u == 0) ? D0 : ((u == 1) ? D1 : D2);
    m   = (u == 2) ? (v & 32'h0000_FFFF) : (v & 32'h0000_007F);
    acc = cyc + 1;
    set_in(u, 1'b1, m);
    e      = model(64'(m), dg);
    e.unit = u;
    e.cyc  = acc + longint'(bw) + 1;
    q.push_back(e);
    last_acc[u] = acc;
    @(negedge clk);
    for (int i = 0; i <= bw; i++) begin
      set_in(u, 1'($urandom()), $urandom());
      @(negedge clk);
    end
    set_in(u, 1'b0, $urandom());
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    exp_t   e;
    longint acc;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    for (int u = 0; u < 3; u++) begin
      last_acc[u] = -1000;
      hold_bcd[u] = '0;
      hold_ovf[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(0, 32'd127, 2);
    issue(0, 32'd0, 1);
    issue(1, 32'd100, 0);
    issue(2, 32'd65535, 1);
    issue(1, 32'd99, 0);

    // start held high for 20 cycles with binIn=5: accepts every 9 cycles
    for (int i = 0; i < 20; i++) begin
      if (i % 9 == 0) begin
        acc    = cyc + 1;
        e      = model(64'd5, D0);
        e.unit = 0;
        e.cyc  = acc + BW0 + 1;
        q.push_back(e);
        last_acc[0] = acc;
      end
      start0 = 1'b1;
      bin0   = 7'd5;
      @(negedge clk);
    end
    start0 = 1'b0;
    repeat (BW0 + 3) @(negedge clk);

    // Randomized conversions
    for (int i = 0; i < 24; i++) issue(0, $urandom_range(0, 127), $urandom_range(0, 3));
    for (int i = 0; i < 12; i++) issue(1, $urandom_range(0, 127), $urandom_range(0, 2));
    for (int i = 0; i < 6; i++)  issue(2, $urandom(), $urandom_range(0, 2));

    // Reset during the conversion of 99: no done, outputs cleared
    acc = cyc + 1;
    start0 = 1'b1;
    bin0   = 7'd99;
    e      = model(64'd99, D0);
    e.unit = 0;
    e.cyc  = acc + BW0 + 1;
    q.push_back(e);
    last_acc[0] = acc;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    for (int u = 0; u < 3; u++) last_acc[u] = -1000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'd42, 3);

    repeat (5) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d outstanding expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
- REQ-001 Parameter BIN_WIDTH, default 7: width of the binary input, legal range 4..32.
- REQ-002 Parameter DIGITS, default 3: number of BCD output digits, legal range 1..10.
- REQ-003 clk  input  1: single clock; all state changes on its rising edge.
- REQ-004 rst_n  input  1: asynchronous, active-low reset.
- REQ-005 start  input  1: request to convert binIn; sampled only in IDLE.
- REQ-006 binIn  input  BIN_WIDTH: unsigned binary operand; captured on the accepted start cycle.
- REQ-007 busy  output  1: high while a conversion is in progress (states SHIFT and DONE).
- REQ-008 done  output  1: single-cycle pulse marking that bcdOut holds a new result.
- REQ-009 bcdOut  output  4*DIGITS: result, digit k at bits [4k+3:4k], digit 0 is the ones digit.
- REQ-010 overflow  output  1: high when the last result did not fit in DIGITS digits.

Function
- REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
- REQ-012 IDLE with start=1: capture binIn into the shift register, clear the BCD scratch register and the shift counter, and go to SHIFT.
- REQ-013 SHIFT, each cycle, in this order: add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one bit.
- REQ-014 SHIFT SHALL run exactly BIN_WIDTH cycles, then go to DONE.
- REQ-015 DONE: load bcdOut and overflow from scratch, assert done for one cycle, go to IDLE.
- REQ-016 Latency: start accepted at edge N gives done=1 in the cycle after edge N+BIN_WIDTH+1; the next start is accepted at edge N+BIN_WIDTH+2 at the earliest.
- REQ-017 start while busy=1 SHALL be ignored: no capture and no effect on the conversion in flight.
- REQ-018 binIn changes after the capture cycle SHALL NOT affect the result.
- REQ-019 overflow SHALL be set if any 1 bit is shifted out of the top scratch digit during the conversion; bcdOut then holds the value modulo 10^DIGITS.
- REQ-020 bcdOut and overflow SHALL hold their values from DONE until the next DONE.
- REQ-021 All outputs SHALL be registered; there is no combinational path from an input to an output.
- REQ-022 Every scratch digit SHALL be in the range 0..9 after each SHIFT cycle.

Reset
- REQ-023 rst_n=0 SHALL force, asynchronously: state IDLE, busy=0, done=0, bcdOut=0, overflow=0, and clear the scratch register, operand register and counter.
- REQ-024 Reset mid-conversion SHALL abandon the conversion, emit no done pulse and leave no partial result on bcdOut.
- REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
- REQ-026 Macro BCD_LEADING_BLANK_EN.
- REQ-027 With the macro defined: in DONE, every digit more significant than the highest nonzero digit SHALL be loaded as 4'hF (display blank). Digit 0 is never blanked. Overflow results are not blanked.
- REQ-028 Without the macro: all digits are loaded as plain BCD, including leading zeros; no blanking logic is present.

Verification
- REQ-029 Defaults, binIn=127 with start pulsed → done exactly 8 cycles after start; bcdOut=12'h127; overflow=0.
- REQ-030 Defaults, binIn=0 → bcdOut=12'h000 without the macro, 12'hFF0 with it.
- REQ-031 Defaults, binIn=5 then start held high for 20 cycles → back-to-back conversions every 9 cycles; each done pulse is 1 cycle; bcdOut=12'h005 (12'hFF5 with the macro).
- REQ-032 DIGITS=2, binIn=100 → overflow=1; bcdOut=8'h00.
- REQ-033 rst_n pulsed low at cycle 4 of the conversion of 99 → no done pulse; all outputs 0; a fresh start with 42 gives bcdOut=12'h042.
- REQ-034 BIN_WIDTH=16, DIGITS=5, binIn=65535 → bcdOut=20'h65535; done 17 cycles after start.
